// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit.
// Moore FSM driving datapath controls, with optional memory handshake.
module multicycle_ctrl #(
  parameter int ALUOP_W       = 2,
  parameter int MEM_HANDSHAKE = 0,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op_code,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ior_d,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_wr,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic [1:0]         br_type,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;

  localparam logic [ALUOP_W-1:0] AOP_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AOP_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AOP_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AOP_OR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AOP_SLT   = ALUOP_W'(4);

  state_t             state_q;
  state_t             state_d;
  logic [5:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready;
  logic               retire;
  logic               is_r;
  logic               is_mem;
  logic               is_br;
  logic               is_j;
  logic               is_imm;

  // Without the handshake every memory access completes in one cycle.
  assign ready = (MEM_HANDSHAKE == 0) || mem_ready;

  assign is_r   = (op_code == OP_R);
  assign is_mem = (op_code == OP_LW) || (op_code == OP_SW);
  assign is_br  = (op_code == OP_BEQ) || (op_code == OP_BNE)
                || (op_code == OP_REGIMM);
  assign is_j   = (op_code == OP_J);
  assign is_imm = (op_code == OP_ADDI) || (op_code == OP_ORI);

  assign state     = state_q;
  assign instr_cnt = cnt_q;

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= op_code;
      if (retire)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next-state logic and Moore control outputs; reset forces controls low.
  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_wr        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = AOP_ADD;
    pc_src        = 2'b00;
    br_type       = 2'b00;
    illegal_op    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          is_r:    state_d = S_EXEC;
          is_mem:  state_d = S_MEMADR;
          is_br:   state_d = S_BRANCH;
          is_j:    state_d = S_JUMP;
          is_imm:  state_d = S_IEXEC;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_rd  = 1'b1;
        ior_d   = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_wr  = 1'b1;
        ior_d   = 1'b1;
        if (ready)
          retire  = 1'b1;
        else
          state_d = S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_FUNCT;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        retire        = 1'b1;
        unique case (op_q)
          OP_BNE:    br_type = 2'b01;
          OP_REGIMM: br_type = 2'b10;
          default:   br_type = 2'b00;
        endcase
        if (ALUOP_W == 3 && op_q == OP_REGIMM)
          alu_op = AOP_SLT;
        else
          alu_op = AOP_SUB;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_ORI) ? AOP_OR : AOP_ADD;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_wr = 1'b1;
        retire = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ior_d         = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_wr        = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = '0;
      pc_src        = 2'b00;
      br_type       = 2'b00;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl.
// u0: default params; u1: ALUOP_W=3, MEM_HANDSHAKE=1, CNT_W=4.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] RGI = 6'b000001;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [2:0]  aop;
    logic [15:0] cnt;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1, rdy0, rdy1;
  logic [5:0] op0, op1;

  logic pw0, pwc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rwr0, asa0, ill0;
  logic [1:0] asb0, psrc0, brt0, aop0;
  logic [3:0] st0;
  logic [15:0] cnt0;

  logic pw1, pwc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rwr1, asa1, ill1;
  logic [1:0] asb1, psrc1, brt1;
  logic [2:0] aop1;
  logic [3:0] st1;
  logic [3:0] cnt1;

  exp_t sb[$];
  int   cnt_exp[2];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl u0 (
    .clk(clk), .rst(rst0), .op_code(op0), .mem_ready(rdy0),
    .pc_write(pw0), .pc_write_cond(pwc0), .ior_d(iod0),
    .mem_rd(mrd0), .mem_wr(mwr0), .ir_write(irw0),
    .mem_to_reg(m2r0), .reg_dst(rdst0), .reg_wr(rwr0),
    .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
    .pc_src(psrc0), .br_type(brt0), .illegal_op(ill0),
    .state(st0), .instr_cnt(cnt0)
  );

  multicycle_ctrl #(
    .ALUOP_W(3), .MEM_HANDSHAKE(1), .CNT_W(4)
  ) u1 (
    .clk(clk), .rst(rst1), .op_code(op1), .mem_ready(rdy1),
    .pc_write(pw1), .pc_write_cond(pwc1), .ior_d(iod1),
    .mem_rd(mrd1), .mem_wr(mwr1), .ir_write(irw1),
    .mem_to_reg(m2r1), .reg_dst(rdst1), .reg_wr(rwr1),
    .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
    .pc_src(psrc1), .br_type(brt1), .illegal_op(ill1),
    .state(st1), .instr_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  // Expected {controls, alu_op} for a state, from the control table.
  function automatic logic [19:0] model(input int s, input logic [5:0] op,
                                        input bit rdy, input int w);
    bit pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, ill;
    logic [1:0] asb, psrc, brt;
    logic [2:0] aop;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, ill} = '0;
    asb = 2'b00; psrc = 2'b00; brt = 2'b00; aop = 3'd0;
    case (s)
      0: begin mrd = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rwr = 1; m2r = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin asa = 1; aop = 3'd2; end
      7: begin rwr = 1; rdst = 1; end
      8: begin
        asa = 1; pwc = 1; psrc = 2'b01;
        brt = (op == BNE) ? 2'b01 : (op == RGI) ? 2'b10 : 2'b00;
        aop = (w == 3 && op == RGI) ? 3'd4 : 3'd1;
      end
      9: begin pw = 1; psrc = 2'b10; end
      10: begin
        asa = 1; asb = 2'b10;
        aop = (op == ORI) ? 3'd3 : 3'd0;
      end
      11: rwr = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa,
            asb, psrc, brt, ill, aop};
  endfunction

  function automatic logic [19:0] obs(input bit sel);
    if (sel)
      return {pw1, pwc1, iod1, mrd1, mwr1, irw1, m2r1, rdst1, rwr1,
              asa1, asb1, psrc1, brt1, ill1, aop1};
    return {pw0, pwc0, iod0, mrd0, mwr0, irw0, m2r0, rdst0, rwr0,
            asa0, asb0, psrc0, brt0, ill0, 1'b0, aop0};
  endfunction

  task automatic push(input bit sel, input int s, input logic [5:0] op,
                      input bit rdy);
    exp_t e;
    logic [19:0] m;
    m = model(s, op, sel ? rdy : 1'b1, sel ? 3 : 2);
    e.st  = 4'(s);
    e.ctl = m[19:3];
    e.aop = m[2:0];
    e.cnt = 16'(cnt_exp[sel]);
    e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic set_op(input bit sel, input logic [5:0] op);
    if (sel) op1 = op;
    else     op0 = op;
  endtask

  task automatic set_rdy(input bit sel, input bit r);
    if (sel) rdy1 = r;
    else     rdy0 = 1'($urandom_range(0, 1));
  endtask

  task automatic set_rst(input bit sel, input bit r);
    if (sel) rst1 = r;
    else     rst0 = r;
  endtask

  // Pop one expectation per cycle and compare at the falling edge.
  task automatic drain(input bit sel, input logic [5:0] op);
    exp_t e;
    logic [19:0] o;
    string p;
    p = sel ? "u1" : "u0";
    set_op(sel, op);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      set_rdy(sel, e.rdy);
      @(negedge clk);
      o = obs(sel);
      chk($sformatf("%s op%b state", p, op),
          {28'd0, sel ? st1 : st0}, {28'd0, e.st});
      chk($sformatf("%s op%b s%0d ctl", p, op, e.st),
          {15'd0, o[19:3]}, {15'd0, e.ctl});
      chk($sformatf("%s op%b s%0d alu_op", p, op, e.st),
          {29'd0, o[2:0]}, {29'd0, e.aop});
      chk($sformatf("%s op%b s%0d instr_cnt", p, op, e.st),
          {16'd0, sel ? {12'd0, cnt1} : cnt0}, {16'd0, e.cnt});
      @(posedge clk);
      #1;
      if (e.st == 4'd1)
        set_op(sel, ~op);
    end
  endtask

  task automatic instr(input bit sel, input logic [5:0] op,
                       input int wf, input int ww);
    bit ret;
    ret = 1'b1;
    for (int i = 0; i < wf; i++) push(sel, 0, op, 1'b0);
    push(sel, 0, op, 1'b1);
    push(sel, 1, op, 1'b0);
    case (op)
      LW: begin
        push(sel, 2, op, 1'b0);
        for (int i = 0; i < ww; i++) push(sel, 3, op, 1'b0);
        push(sel, 3, op, 1'b1);
        push(sel, 4, op, 1'b0);
      end
      SW: begin
        push(sel, 2, op, 1'b0);
        for (int i = 0; i < ww; i++) push(sel, 5, op, 1'b0);
        push(sel, 5, op, 1'b1);
      end
      RT:            begin push(sel, 6, op, 1'b0); push(sel, 7, op, 1'b1); end
      BEQ, BNE, RGI: push(sel, 8, op, 1'b0);
      JMP:           push(sel, 9, op, 1'b0);
      ADI, ORI:      begin push(sel, 10, op, 1'b0); push(sel, 11, op, 1'b0); end
      default: begin push(sel, 12, op, 1'b0); ret = 1'b0; end
    endcase
    drain(sel, op);
    if (ret)
      cnt_exp[sel] = (cnt_exp[sel] + 1) % (sel ? 16 : 65536);
  endtask

  task automatic reset_chk(input bit sel);
    logic [19:0] o;
    set_rst(sel, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = obs(sel);
    chk(sel ? "u1 rst state" : "u0 rst state",
        {28'd0, sel ? st1 : st0}, 32'd0);
    chk(sel ? "u1 rst ctl" : "u0 rst ctl", {12'd0, o}, 32'd0);
    chk(sel ? "u1 rst cnt" : "u0 rst cnt",
        {16'd0, sel ? {12'd0, cnt1} : cnt0}, 32'd0);
    @(posedge clk);
    #1;
    set_rst(sel, 1'b0);
    cnt_exp[sel] = 0;
  endtask

  // Reset lands while the LW sits in MEMRD; no write-back may follow.
  task automatic abort_lw(input bit sel);
    logic [19:0] o;
    push(sel, 0, LW, 1'b1);
    push(sel, 1, LW, 1'b1);
    push(sel, 2, LW, 1'b1);
    drain(sel, LW);
    set_rst(sel, 1'b1);
    set_rdy(sel, 1'b1);
    @(negedge clk);
    o = obs(sel);
    chk(sel ? "u1 abort state" : "u0 abort state",
        {28'd0, sel ? st1 : st0}, 32'd3);
    chk(sel ? "u1 abort ctl" : "u0 abort ctl", {12'd0, o}, 32'd0);
    @(posedge clk);
    #1;
    set_rst(sel, 1'b0);
    cnt_exp[sel] = 0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    rdy0 = 1'b0; rdy1 = 1'b0;
    op0  = 6'd0; op1  = 6'd0;
    cnt_exp[0] = 0;
    cnt_exp[1] = 0;

    reset_chk(1'b0);
    instr(1'b0, LW,  0, 0);
    instr(1'b0, BNE, 0, 0);
    instr(1'b0, BAD, 0, 0);
    instr(1'b0, SW,  0, 0);
    instr(1'b0, RT,  0, 0);
    instr(1'b0, BEQ, 0, 0);
    instr(1'b0, RGI, 0, 0);
    instr(1'b0, JMP, 0, 0);
    instr(1'b0, ADI, 0, 0);
    instr(1'b0, ORI, 0, 0);
    instr(1'b0, 6'b010101, 0, 0);
    abort_lw(1'b0);
    instr(1'b0, ADI, 0, 0);

    reset_chk(1'b1);
    instr(1'b1, LW,  1, 2);
    instr(1'b1, SW,  2, 3);
    instr(1'b1, ORI, 0, 0);
    instr(1'b1, RGI, 1, 0);
    instr(1'b1, ADI, 0, 0);
    for (int i = 0; i < 16; i++)
      instr(1'b1, JMP, i % 2, 0);
    instr(1'b1, BEQ, 0, 0);
    instr(1'b1, BAD, 0, 0);
    instr(1'b1, RT,  0, 0);
    abort_lw(1'b1);
    instr(1'b1, JMP, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUOP_W, default 2, width of alu_op; legal values 2 or 3.
REQ-002 Parameter MEM_HANDSHAKE, default 0; 1 = memory states wait on mem_ready.
REQ-003 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 op_code  input  6  opcode of instruction register, sampled in DECODE.
REQ-006 mem_ready  input  1  memory access complete; ignored when MEM_HANDSHAKE=0.
REQ-007 pc_write, pc_write_cond, ior_d, mem_rd, mem_wr, ir_write, mem_to_reg, reg_dst, reg_wr, alu_src_a  output  1 each  datapath controls.
REQ-008 alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-009 alu_op  output  ALUOP_W  ALU operation class.
REQ-010 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 br_type  output  2  00 BEQ, 01 BNE, 10 REGIMM.
REQ-012 illegal_op  output  1  one-cycle pulse on unknown opcode.
REQ-013 state  output  4  current state code (debug); instr_cnt  output  CNT_W  retired instructions.

Function
REQ-014 States, codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, ILLEGAL 12; codes 13-15 SHALL go to FETCH next cycle with all controls 0.
REQ-015 FETCH: mem_rd=1, ior_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00, pc_write=1 -> DECODE.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=add; next state by op_code: 000000 EXEC; 100011/101011 MEMADR; 000100/000101/000001 BRANCH; 000010 JUMP; 001000/001101 IEXEC; any other ILLEGAL.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, add -> MEMRD (LW) or MEMWR (SW); MEMRD: mem_rd=1, ior_d=1 -> MEMWB; MEMWB: reg_wr=1, mem_to_reg=1, reg_dst=0 -> FETCH; MEMWR: mem_wr=1, ior_d=1 -> FETCH.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, alu_op=funct -> RWB; RWB: reg_wr=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_src=01, br_type per DECODE opcode (latched), alu_op=sub (slt when ALUOP_W=3 and REGIMM) -> FETCH.
REQ-020 JUMP: pc_write=1, pc_src=10 -> FETCH.
REQ-021 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=add (ADDI) or or (ORI) -> IWB; IWB: reg_wr=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-022 ILLEGAL: illegal_op=1 for exactly that cycle, no writes -> FETCH; instr_cnt not incremented.
REQ-023 alu_op encoding: ALUOP_W=2: add 00, sub 01, funct 10, or 11, REGIMM uses sub; ALUOP_W=3: add 000, sub 001, funct 010, or 011, slt 100.
REQ-024 Controls SHALL be Moore outputs of state (plus latched opcode class); op_code SHALL be latched in DECODE and ignored elsewhere.
REQ-025 MEM_HANDSHAKE=1: FETCH, MEMRD, MEMWR hold while mem_ready=0 with mem_rd/mem_wr held asserted; ir_write, pc_write (FETCH) and exit SHALL occur only in the cycle mem_ready=1.
REQ-026 Latency (MEM_HANDSHAKE=0, cycles FETCH to next FETCH): LW 5, SW 4, R 4, ADDI/ORI 4, branch 3, J 3, illegal 3.
REQ-027 instr_cnt SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP, IWB; wraps from 2^CNT_W-1 to 0.

Reset
REQ-028 While rst=1 at a clk edge: state<=FETCH, instr_cnt<=0, latched opcode<=0; all control outputs SHALL read 0 while rst=1.
REQ-029 Reset asserted mid-instruction SHALL abort it with no further writes; first cycle after rst deasserts is FETCH.

Verification
REQ-030 Reset, then LW (100011), MEM_HANDSHAKE=0 -> states 0,1,2,3,4,0; reg_wr=1 and mem_to_reg=1 only in state 4; instr_cnt 0->1.
REQ-031 BNE (000101) -> states 0,1,8,0; in state 8 pc_write_cond=1, pc_src=01, br_type=01, alu_op=01.
REQ-032 op_code 111111 -> states 0,1,12,0; illegal_op high one cycle; instr_cnt unchanged.
REQ-033 MEM_HANDSHAKE=1, SW with mem_ready low 3 cycles in MEMWR -> mem_wr=1 for 4 cycles, exit to FETCH on ready cycle; FETCH with ready low -> no ir_write/pc_write until ready.
REQ-034 ALUOP_W=3, ORI (001101) -> IEXEC alu_op=011; REGIMM (000001) -> BRANCH alu_op=100, br_type=10.
REQ-035 CNT_W=4, 16 J instructions -> instr_cnt wraps to 0; rst asserted in MEMRD -> next state FETCH, instr_cnt=0, no reg_wr.
